// File: rtl/iccm_mem_arbiter_if.sv
// ICCM arbiter signal bundle: loader stream, TL-UL bus side and SRAM side.
// slave = arbiter view, master = surrounding logic / bench view.
interface iccm_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);

  logic          ld_req_i;
  logic [AW-1:0] ld_addr_i;
  logic [DW-1:0] ld_wdata_i;
  logic          ld_gnt_o;

  logic          bus_req_i;
  logic          bus_we_i;
  logic [AW-1:0] bus_addr_i;
  logic [DW-1:0] bus_wdata_i;
  logic [DW-1:0] bus_wmask_i;
  logic          bus_gnt_o;
  logic          bus_rvalid_o;
  logic [DW-1:0] bus_rdata_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_wmask_o;
  logic [DW-1:0] mem_rdata_i;

  logic [1:0]    owner_o;
  logic [15:0]   ld_wr_cnt_o;

  modport slave (
    input  ld_req_i,
    input  ld_addr_i,
    input  ld_wdata_i,
    output ld_gnt_o,
    input  bus_req_i,
    input  bus_we_i,
    input  bus_addr_i,
    input  bus_wdata_i,
    input  bus_wmask_i,
    output bus_gnt_o,
    output bus_rvalid_o,
    output bus_rdata_o,
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_wmask_o,
    input  mem_rdata_i,
    output owner_o,
    output ld_wr_cnt_o
  );

  modport master (
    output ld_req_i,
    output ld_addr_i,
    output ld_wdata_i,
    input  ld_gnt_o,
    output bus_req_i,
    output bus_we_i,
    output bus_addr_i,
    output bus_wdata_i,
    output bus_wmask_i,
    input  bus_gnt_o,
    input  bus_rvalid_o,
    input  bus_rdata_o,
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_wmask_o,
    output mem_rdata_i,
    input  owner_o,
    input  ld_wr_cnt_o
  );

endinterface

// File: rtl/iccm_mem_arbiter.sv
// ICCM single-port SRAM arbiter: loader priority, bus anti-starvation,
// 1-cycle read return to the bus side, saturating loader write count.
module iccm_mem_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic               clk_i,
  input logic               system_rst_ni,
  iccm_mem_arbiter_if.slave arb
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_LD   = 2'd1,
    OWN_BUS  = 2'd2
  } owner_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  owner_e      owner_q;
  owner_e      owner_d;
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic        rd_pend_q;
  logic        rd_pend_d;
  logic [15:0] wr_cnt_q;
  logic [15:0] wr_cnt_d;

  logic        force_bus;
  logic        ld_gnt;
  logic        bus_gnt;

  // Grants; gated by reset so nothing reaches the SRAM while held in reset.
  always_comb begin
    force_bus = arb.bus_req_i & arb.ld_req_i
              & (starve_q == SMAX);
    ld_gnt    = system_rst_ni & arb.ld_req_i & ~force_bus;
    bus_gnt   = system_rst_ni & arb.bus_req_i & ~ld_gnt;
  end

  // SRAM port mux: loader writes full words, bus reads carry no mask.
  always_comb begin
    arb.mem_req_o   = 1'b0;
    arb.mem_we_o    = 1'b0;
    arb.mem_addr_o  = '0;
    arb.mem_wdata_o = '0;
    arb.mem_wmask_o = '0;
    unique case (1'b1)
      ld_gnt: begin
        arb.mem_req_o   = 1'b1;
        arb.mem_we_o    = 1'b1;
        arb.mem_addr_o  = arb.ld_addr_i;
        arb.mem_wdata_o = arb.ld_wdata_i;
        arb.mem_wmask_o = '1;
      end
      bus_gnt: begin
        arb.mem_req_o   = 1'b1;
        arb.mem_we_o    = arb.bus_we_i;
        arb.mem_addr_o  = arb.bus_addr_i;
        arb.mem_wdata_o = arb.bus_wdata_i;
        arb.mem_wmask_o = arb.bus_we_i ?
                          arb.bus_wmask_i : '0;
      end
      default: ;
    endcase
  end

  // Starvation count: loader wins while bus waits; any bus slot clears it.
  always_comb begin
    starve_d = starve_q;
    if (!arb.bus_req_i || bus_gnt) begin
      starve_d = '0;
    end else if (ld_gnt && (starve_q < SMAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Owner next state follows whichever side holds the port this cycle.
  always_comb begin
    owner_d = OWN_IDLE;
    unique case (1'b1)
      ld_gnt:  owner_d = OWN_LD;
      bus_gnt: owner_d = OWN_BUS;
      default: owner_d = OWN_IDLE;
    endcase
  end

  // Read-pending flag and saturating loader write count.
  always_comb begin
    rd_pend_d = bus_gnt & ~arb.bus_we_i;
    wr_cnt_d  = wr_cnt_q;
    if (ld_gnt && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge system_rst_ni) begin
    if (!system_rst_ni) begin
      owner_q   <= OWN_IDLE;
      starve_q  <= '0;
      rd_pend_q <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      rd_pend_q <= rd_pend_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Outputs; read data is only passed through on the return cycle.
  always_comb begin
    arb.ld_gnt_o     = ld_gnt;
    arb.bus_gnt_o    = bus_gnt;
    arb.bus_rvalid_o = rd_pend_q;
    arb.bus_rdata_o  = rd_pend_q ? arb.mem_rdata_i : '0;
    arb.owner_o      = owner_q;
    arb.ld_wr_cnt_o  = wr_cnt_q;
  end

endmodule

// File: doc/iccm_mem_arbiter.md
Name: iccm_mem_arbiter

Overview:
Arbitrates the single-port instruction SRAM (instr_mem_top) between two requesters: the UART program loader (iccm_controller write stream) and the TL-UL bus path (tlul_sram_adapter on the ICCM xbar port).
- Loader has priority.
- A starvation counter guarantees the bus a slot under sustained loader traffic.
- The block tracks the 1-cycle SRAM read latency and returns rvalid/rdata to the bus side only.
- Sits between iccm_controller/tlul_sram_adapter and instr_mem_top, replacing the ad-hoc reset-based address mux.

Parameters:
AW, 12, SRAM word-address width
DW, 32, data width
STARVE_MAX, 4, max consecutive loader grants while bus_req_i is held before the bus is forced one slot (legal range 1..15)

Ports:
clk_i  input  1  clock
system_rst_ni  input  1  asynchronous active-low reset
ld_req_i  input  1  loader write request
ld_addr_i  input  AW  loader word address
ld_wdata_i  input  DW  loader write data (full-word write)
ld_gnt_o  output  1  loader granted this cycle
bus_req_i  input  1  bus request
bus_we_i  input  1  bus write enable
bus_addr_i  input  AW  bus word address
bus_wdata_i  input  DW  bus write data
bus_wmask_i  input  DW  bus bit write mask
bus_gnt_o  output  1  bus granted this cycle
bus_rvalid_o  output  1  bus read data valid
bus_rdata_o  output  DW  bus read data
mem_req_o  output  1  SRAM request
mem_we_o  output  1  SRAM write enable
mem_addr_o  output  AW  SRAM address
mem_wdata_o  output  DW  SRAM write data
mem_wmask_o  output  DW  SRAM bit write mask
mem_rdata_i  input  DW  SRAM read data, valid 1 cycle after a read request
owner_o  output  2  owner of the previous cycle: 0 IDLE, 1 LD, 2 BUS
ld_wr_cnt_o  output  16  loader writes completed, saturating at 16'hFFFF

Behaviour:
Reset: system_rst_ni is asynchronous, active-low; clock is clk_i.
- All flops clear on reset: owner_q=IDLE, starve_cnt=0, rd_pend=0, ld_wr_cnt=0.
- Every output reads 0 during reset.

Grant (combinational, same cycle as request):
- force_bus = bus_req_i & ld_req_i & (starve_cnt == STARVE_MAX).
- ld_gnt_o = ld_req_i & ~force_bus.
- bus_gnt_o = bus_req_i & ~ld_gnt_o.
- At most one grant per cycle.

SRAM drive:
- Loader granted: mem_req_o=1, mem_we_o=1, mem_addr_o=ld_addr_i, mem_wdata_o=ld_wdata_i, mem_wmask_o=all ones.
- Bus granted: mem_* follow the bus_* inputs; mem_wmask_o=bus_wmask_i on writes, 0 on reads.
- No grant: mem_req_o=0 and all mem_* outputs=0.

Starvation counter:
- Width 4.
- Increments on each ld_gnt_o cycle while bus_req_i=1.
- Clears on a bus_gnt_o cycle or any cycle with bus_req_i=0.
- Never exceeds STARVE_MAX.

Owner state machine (IDLE/LD/BUS):
- owner_q <= LD on ld_gnt_o, BUS on bus_gnt_o, otherwise IDLE.
- owner_o = owner_q.

Read return:
- rd_pend <= bus_gnt_o & ~bus_we_i.
- bus_rvalid_o = rd_pend.
- bus_rdata_o = rd_pend ? mem_rdata_i : 0.
- Loader grants and bus writes produce no rvalid.
- Back-to-back bus reads give rvalid on consecutive cycles.

Write counter:
- ld_wr_cnt increments by 1 on each ld_gnt_o cycle.
- Holds at 16'hFFFF once reached.

Boundary cases:
- Simultaneous requests, counter below STARVE_MAX: loader wins; bus_req_i must be held until granted.
- Bus read granted in the cycle before a loader grant: rvalid/rdata still returned correctly in the next cycle; the loader write does not corrupt the returned data.
- Reset asserted mid-read: the pending rvalid is dropped and not re-issued.
- Loader only, no bus traffic: a grant every cycle, counter stays 0.

Test Plan:
- Reset check: hold system_rst_ni=0 and toggle inputs -> every output is 0; owner_o=0; ld_wr_cnt_o=0.
- Loader-only stream: ld_req_i=1 for 8 cycles, addr 0..7, data 32'hA5A5_0000+i -> ld_gnt_o=1 each cycle; mem_we_o=1; mem_wmask_o=32'hFFFF_FFFF; ld_wr_cnt_o=8; owner_o=1 one cycle after each grant.
- Bus read: bus_req_i=1, bus_we_i=0, addr 12'h010; memory returns 32'hDEAD_BEEF -> bus_gnt_o same cycle; bus_rvalid_o=1 and bus_rdata_o=32'hDEAD_BEEF exactly 1 cycle later; no rvalid on a bus write with bus_wmask_i=32'h0000_FFFF.
- Starvation: ld_req_i and bus_req_i both held, STARVE_MAX=4 -> grant pattern L,L,L,L,B repeating; starve_cnt returns to 0 after each B.
- Bus read then loader write: bus read at cycle N, loader write at N+1 -> rvalid at N+1 with the correct read data; the write is issued at N+1.
- Reset mid-read: bus read granted, reset asserted the next cycle -> bus_rvalid_o stays 0; ld_wr_cnt_o clears; normal arbitration resumes after release.
